memory_access_stage: RTL and testbench



---
 rtl/rv32_mem_pkg.sv | 19 +
 rtl/load_store_align.sv | 82 ++++++++
 rtl/memory_access_stage.sv | 155 +++++++++++++++
 tb/tb_memory_access_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 memory-access stage: funct3 codes and FSM encoding.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ma_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational access checker and lane formatter: fault detection, byte enables,
// store-data replication, and load byte/half extraction with sign/zero extension.
module load_store_align
  import rv32_mem_pkg::*;
(
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic        fault_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    fault_o = 1'b0;
    if (mem_read_i && mem_write_i) begin
      fault_o = 1'b1;
    end else if (mem_read_i) begin
      case (funct3_i)
        F3_LB, F3_LBU: fault_o = 1'b0;
        F3_LH, F3_LHU: fault_o = addr_i[0];
        F3_LW:         fault_o = (addr_i[1:0] != 2'b00);
        default:       fault_o = 1'b1;
      endcase
    end else if (mem_write_i) begin
      case (funct3_i)
        F3_SB:   fault_o = 1'b0;
        F3_SH:   fault_o = addr_i[0];
        F3_SW:   fault_o = (addr_i[1:0] != 2'b00);
        default: fault_o = 1'b1;
      endcase
    end
  end

  // Size lives in funct3[1:0] for both loads and stores.
  always_comb begin
    byte_en_o = 4'b1111;
    wdata_o   = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        byte_en_o = 4'b0001 << addr_i[1:0];
        wdata_o   = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        byte_en_o = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{store_data_i[15:0]}};
      end
      default: begin
        byte_en_o = 4'b1111;
        wdata_o   = store_data_i;
      end
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_funct3_i)
      F3_LB:   load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data_o = {24'd0, ld_byte};
      F3_LH:   load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data_o = {16'd0, ld_half};
      F3_LW:   load_data_o = rdata_i;
      default: load_data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// RV32IM memory-access stage: request/ready transaction with data memory,
// stall generation while outstanding, formatted load result to MA/WB.
module memory_access_stage
  import rv32_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALU_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        regwrite_enable,
  input  logic        MUX3_select,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] read_data,
  output logic [31:0] ALU_out_out,
  output logic [4:0]  rd_out,
  output logic        MUX3_select_out,
  output logic        regwrite_enable_out,
  output logic        stall,
  output logic        mem_fault
);

  ma_state_e   state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] read_data_q, read_data_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        is_load_q, is_load_d;

  logic        access;
  logic        fault;
  logic [3:0]  fmt_byte_en;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        stall_c;
  logic        fault_c;

  assign access = mem_read | mem_write;

  load_store_align u_align (
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (ALU_out),
    .store_data_i (store_data),
    .ld_funct3_i  (ld_funct3_q),
    .ld_off_i     (ld_off_q),
    .rdata_i      (mem_rdata),
    .fault_o      (fault),
    .byte_en_o    (fmt_byte_en),
    .wdata_o      (fmt_wdata),
    .load_data_o  (fmt_load)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_byte_en_q <= 4'd0;
      read_data_q   <= 32'd0;
      ld_funct3_q   <= 3'd0;
      ld_off_q      <= 2'd0;
      is_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      read_data_q   <= read_data_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_off_q      <= ld_off_d;
      is_load_q     <= is_load_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    read_data_d   = read_data_q;
    ld_funct3_d   = ld_funct3_q;
    ld_off_d      = ld_off_q;
    is_load_d     = is_load_q;
    stall_c       = 1'b0;
    fault_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && fault) begin
          fault_c = 1'b1;
        end else if (access) begin
          stall_c       = 1'b1;
          state_d       = ST_BUSY;
          mem_req_d     = 1'b1;
          mem_we_d      = mem_write;
          mem_addr_d    = {ALU_out[31:2], 2'b00};
          mem_wdata_d   = fmt_wdata;
          mem_byte_en_d = fmt_byte_en;
          ld_funct3_d   = funct3;
          ld_off_d      = ALU_out[1:0];
          is_load_d     = mem_read;
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          read_data_d = is_load_q ? fmt_load : 32'd0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // MA/WB captures read_data at this edge; clear it so IDLE shows 0.
        read_data_d = 32'd0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req             = mem_req_q;
  assign mem_we              = mem_we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = mem_wdata_q;
  assign mem_byte_en         = mem_byte_en_q;
  assign read_data           = read_data_q;
  assign stall               = stall_c & RESETN;
  assign mem_fault           = fault_c & RESETN;
  assign regwrite_enable_out = regwrite_enable & ~mem_fault;
  assign ALU_out_out         = ALU_out;
  assign rd_out              = rd;
  assign MUX3_select_out     = MUX3_select;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected load results are queued at issue
// and popped in the DONE cycle; bus fields and stall counts are checked inline.
module tb_memory_access_stage;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] ALU_out, store_data;
  logic [4:0]  rd;
  logic        regwrite_enable, MUX3_select;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] read_data, ALU_out_out;
  logic [4:0]  rd_out;
  logic        MUX3_select_out, regwrite_enable_out, stall, mem_fault;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  memory_access_stage dut (
    .CLK(CLK), .RESETN(RESETN), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .ALU_out(ALU_out), .store_data(store_data), .rd(rd),
    .regwrite_enable(regwrite_enable), .MUX3_select(MUX3_select),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .read_data(read_data), .ALU_out_out(ALU_out_out), .rd_out(rd_out),
    .MUX3_select_out(MUX3_select_out), .regwrite_enable_out(regwrite_enable_out),
    .stall(stall), .mem_fault(mem_fault)
  );

  task automatic drive_idle();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; ALU_out = 32'd0;
    store_data = 32'd0; rd = 5'd0; regwrite_enable = 1'b0; MUX3_select = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  // Issues one memory instruction; memory answers on BUSY cycle index 'waits'.
  task automatic run_mem(input string name, input logic rd_i, input logic wr_i,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int waits, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_read);
    int stalls;
    logic [31:0] exp_rd;
    stalls = 0;
    @(negedge CLK);
    mem_read = rd_i; mem_write = wr_i; funct3 = f3; ALU_out = addr; store_data = sdata;
    regwrite_enable = rd_i; rd = 5'd7; MUX3_select = rd_i;
    exp_q.push_back(exp_read);
    #1;
    n_chk++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || mem_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: stall=%b req=%b fault=%b, required 1 0 0", name, stall, mem_req, mem_fault);
    end
    if (stall === 1'b1) stalls++;
    for (int i = 0; i <= waits; i++) begin
      @(negedge CLK);
      n_chk++;
      if (mem_req !== 1'b1 || mem_we !== wr_i || mem_addr !== exp_addr || mem_byte_en !== exp_be) begin
        n_fail++;
        $display("FAIL %s busy%0d: req=%b we=%b addr=%h be=%b, required 1 %b %h %b",
                 name, i, mem_req, mem_we, mem_addr, mem_byte_en, wr_i, exp_addr, exp_be);
      end
      if (wr_i) begin
        n_chk++;
        if (mem_wdata !== exp_wdata) begin
          n_fail++;
          $display("FAIL %s wdata%0d: got %h, required %h", name, i, mem_wdata, exp_wdata);
        end
      end
      if (stall === 1'b1) stalls++;
      if (i == waits) begin
        mem_ready = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
    end
    @(negedge CLK);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_chk++;
    if (read_data !== exp_rd) begin
      n_fail++;
      $display("FAIL %s read_data: got %h, required %h", name, read_data, exp_rd);
    end
    n_chk++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || regwrite_enable_out !== rd_i) begin
      n_fail++;
      $display("FAIL %s done: stall=%b req=%b rwe=%b, required 0 0 %b", name, stall, mem_req,
               regwrite_enable_out, rd_i);
    end
    n_chk++;
    if (stalls != waits + 2) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, waits + 2);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    RESETN = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; ALU_out = 32'h100;
    repeat (2) @(negedge CLK);
    n_chk++;
    if (stall !== 1'b0 || mem_fault !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_byte_en !== 4'd0 || read_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: stall=%b fault=%b req=%b we=%b addr=%h wd=%h be=%b rd=%h, required all 0",
               stall, mem_fault, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en, read_data);
    end
    drive_idle();
    RESETN = 1'b1;
  endtask

  task automatic test_lw();
    run_mem("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0,
            32'h100, 4'b1111, 32'd0, 32'hDEADBEEF);
  endtask

  task automatic test_byte_loads();
    run_mem("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, 0,
            32'h100, 4'b1000, 32'd0, 32'hFFFFFF80);
    run_mem("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, 0,
            32'h100, 4'b1000, 32'd0, 32'h00000080);
  endtask

  task automatic test_store_half();
    run_mem("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0,
            32'h200, 4'b1100, 32'hABCDABCD, 32'd0);
  endtask

  task automatic test_faults();
    logic       f_rd[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       f_wr[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] f_f3[5] = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b001};
    logic [31:0] f_ad[5] = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h201};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      mem_read = f_rd[i]; mem_write = f_wr[i]; funct3 = f_f3[i]; ALU_out = f_ad[i];
      regwrite_enable = 1'b1;
      #1;
      n_chk++;
      if (mem_fault !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || regwrite_enable_out !== 1'b0) begin
        n_fail++;
        $display("FAIL fault%0d: fault=%b stall=%b req=%b rwe=%b, required 1 0 0 0",
                 i, mem_fault, stall, mem_req, regwrite_enable_out);
      end
      @(negedge CLK);
      n_chk++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL fault%0d next: req=%b stall=%b, required 0 0", i, mem_req, stall);
      end
      drive_idle();
    end
  endtask

  task automatic test_nonmem();
    @(negedge CLK);
    drive_idle();
    ALU_out = 32'h55AA_1234; rd = 5'd9; regwrite_enable = 1'b1; MUX3_select = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_chk++;
    if (ALU_out_out !== 32'h55AA_1234 || rd_out !== 5'd9 || MUX3_select_out !== 1'b1 ||
        regwrite_enable_out !== 1'b1 || read_data !== 32'd0 || stall !== 1'b0 || mem_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem: alu=%h rd=%0d mux=%b rwe=%b rdata=%h stall=%b fault=%b",
               ALU_out_out, rd_out, MUX3_select_out, regwrite_enable_out, read_data, stall, mem_fault);
    end
    @(negedge CLK);
    n_chk++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem ready_ignored: req=%b stall=%b, required 0 0", mem_req, stall);
    end
    drive_idle();
  endtask

  task automatic test_lh_wait();
    run_mem("lh_wait", 1'b1, 1'b0, 3'b001, 32'h302, 32'd0, 32'h80017FFF, 3,
            32'h300, 4'b1100, 32'd0, 32'hFFFF8001);
  endtask

  task automatic test_back_to_back();
    run_mem("b2b_sb", 1'b0, 1'b1, 3'b000, 32'h401, 32'h000000A5, 32'd0, 0,
            32'h400, 4'b0010, 32'hA5A5A5A5, 32'd0);
    run_mem("b2b_lhu", 1'b1, 1'b0, 3'b101, 32'h400, 32'd0, 32'h1234F00D, 1,
            32'h400, 4'b0011, 32'd0, 32'h0000F00D);
    run_mem("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h404, 32'hCAFEBABE, 32'd0, 0,
            32'h404, 4'b1111, 32'hCAFEBABE, 32'd0);
    @(negedge CLK);
    drive_idle();
  endtask

  task automatic test_reset_busy();
    @(negedge CLK);
    mem_read = 1'b1; funct3 = 3'b010; ALU_out = 32'h500; regwrite_enable = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy pre: req=%b, required 1", mem_req);
    end
    RESETN = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_busy: req=%b stall=%b addr=%h, required 0 0 0", mem_req, stall, mem_addr);
    end
    drive_idle();
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy after: req=%b stall=%b, required 0 0", mem_req, stall);
    end
    run_mem("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'h0BADF00D, 0,
            32'h600, 4'b1111, 32'd0, 32'h0BADF00D);
    @(negedge CLK);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_store_half();
    @(negedge CLK);
    drive_idle();
    test_faults();
    test_nonmem();
    test_lh_wait();
    @(negedge CLK);
    drive_idle();
    test_back_to_back();
    test_reset_busy();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
